// File: rtl/letc_core_axi_arb_if.sv
// Shared types for the LETC AXI front-end and the AXI4 manager/subordinate interface.
package letc_core_axi_arb_pkg;
  typedef logic [33:0] paddr_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} size_e;
  localparam int ID_W = 4;
endpackage

interface axi_if;
  import letc_core_axi_arb_pkg::*;
  logic [ID_W-1:0] awid;
  paddr_t          awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  word_t           wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  paddr_t          araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  word_t           rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport manager (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport subordinate (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/letc_core_axi_arb.sv
// Round-robin arbiter sharing one AXI4 manager port between single-beat requesters.
// The granted request is latched; all AXI fields come from that copy.
module letc_core_axi_arb_lane
  import letc_core_axi_arb_pkg::*;
(
  input  logic  sel,
  input  logic  err,
  input  word_t rdata,
  output logic  ready,
  output logic  fault,
  output word_t data
);
  assign ready = sel;
  assign fault = sel & err;
  assign data  = sel ? rdata : '0;
endmodule

module letc_core_axi_arb
  import letc_core_axi_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 3,
  parameter int AXI_ID         = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  axi_if.manager                       axi,
  input  logic  [NUM_REQUESTERS-1:0]   i_valid,
  output logic  [NUM_REQUESTERS-1:0]   o_ready,
  output logic  [NUM_REQUESTERS-1:0]   o_fault,
  input  logic  [NUM_REQUESTERS-1:0]   i_wen_nren,
  input  size_e [NUM_REQUESTERS-1:0]   i_size,
  input  paddr_t [NUM_REQUESTERS-1:0]  i_addr,
  input  word_t [NUM_REQUESTERS-1:0]   i_wdata,
  output word_t [NUM_REQUESTERS-1:0]   o_rdata
);
  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wen;
    size_e            size;
    paddr_t           addr;
    word_t            wdata;
  } req_t;

  typedef enum logic [2:0] {IDLE, R_AR, R_DATA, W_AW_W, W_AW, W_W, W_B, FAULT} state_e;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] rr;
  req_t             req;
  logic             found, misaligned, done, err;
  logic [IDX_W-1:0] pick;
  logic             arvalid, awvalid, wvalid, rready, bready;
  logic [3:0]       strb;
  word_t            wdata_rep, lane, rdata_ext, rd;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      c = (int'(rr) + k) % NUM_REQUESTERS;
      if (!found && i_valid[c]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
  end

  assign misaligned = (i_size[pick] == SIZE_HALF && i_addr[pick][0]) ||
                      (i_size[pick] == SIZE_WORD && i_addr[pick][1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:
        if (found) state_nxt = misaligned ? FAULT : (i_wen_nren[pick] ? W_AW_W : R_AR);
      R_AR: begin
        arvalid = 1'b1;
        if (axi.arready) state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          done      = 1'b1;
          err       = axi.rresp != 2'b00;
          state_nxt = IDLE;
        end
      end
      W_AW_W: begin
        awvalid = 1'b1;
        wvalid  = 1'b1;
        case ({axi.awready, axi.wready})
          2'b11:   state_nxt = W_B;
          2'b10:   state_nxt = W_W;
          2'b01:   state_nxt = W_AW;
          default: state_nxt = W_AW_W;
        endcase
      end
      W_AW: begin
        awvalid = 1'b1;
        if (axi.awready) state_nxt = W_B;
      end
      W_W: begin
        wvalid = 1'b1;
        if (axi.wready) state_nxt = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          done      = 1'b1;
          err       = axi.bresp != 2'b00;
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      rr    <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found)
        req <= '{idx: pick, wen: i_wen_nren[pick], size: i_size[pick],
                 addr: i_addr[pick], wdata: i_wdata[pick]};
      if (done) rr <= IDX_W'((int'(req.idx) + 1) % NUM_REQUESTERS);
    end
  end

  // Lane placement for writes and lane extraction for reads, both keyed on the latched address.
  always_comb begin
    strb      = 4'b1111;
    wdata_rep = req.wdata;
    rdata_ext = axi.rdata;
    lane      = axi.rdata >> {req.addr[1:0], 3'b000};
    case (req.size)
      SIZE_BYTE: begin
        strb      = 4'b0001 << req.addr[1:0];
        wdata_rep = {4{req.wdata[7:0]}};
        rdata_ext = {24'b0, lane[7:0]};
      end
      SIZE_HALF: begin
        strb      = req.addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req.wdata[15:0]}};
        rdata_ext = {16'b0, lane[15:0]};
      end
      default: ;
    endcase
  end

  assign rd = (state == R_DATA) ? rdata_ext : '0;

  assign axi.awid    = ID_W'(AXI_ID);
  assign axi.awaddr  = {req.addr[33:2], 2'b00};
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b00;
  assign axi.awvalid = awvalid;
  assign axi.wdata   = wdata_rep;
  assign axi.wstrb   = strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;
  assign axi.arid    = ID_W'(AXI_ID);
  assign axi.araddr  = {req.addr[33:2], 2'b00};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b00;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  logic unused;
  assign unused = ^{axi.bid, axi.rid, axi.rlast, req.wen};

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_lane
    letc_core_axi_arb_lane u_lane (
      .sel   (done && req.idx == IDX_W'(i)),
      .err   (err),
      .rdata (rd),
      .ready (o_ready[i]),
      .fault (o_fault[i]),
      .data  (o_rdata[i])
    );
  end
endmodule

// File: doc/letc_core_axi_arb.md
Name: letc_core_axi_arb

Overview:
- Parametrised, round-robin AXI4 manager front-end for the LETC core.
- Shares one AXI port between N single-beat requesters (MMU, I-cache, D-cache, future units).
- Latches the granted request, runs the address/data/response phases including the B channel, and reports alignment and AXI-response faults back to the requester.

Parameters:
- NUM_REQUESTERS, 3, number of requester channels (>=1).
- AXI_ID, 0, constant ID driven on all AXI ID fields.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- axi  axi_if.manager  -  AXI4 manager port
- i_valid  in  [NUM_REQUESTERS]  request valid, held until o_ready
- o_ready  out  [NUM_REQUESTERS]  one-cycle completion pulse to the granted requester
- o_fault  out  [NUM_REQUESTERS]  qualified by o_ready; 1 = misaligned access or non-OKAY response
- i_wen_nren  in  [NUM_REQUESTERS]  1 = write, 0 = read
- i_size  in  [NUM_REQUESTERS] x size_e  byte/halfword/word
- i_addr  in  [NUM_REQUESTERS] x paddr_t (34b)  byte address
- i_wdata  in  [NUM_REQUESTERS] x word_t  right-aligned write data
- o_rdata  out  [NUM_REQUESTERS] x word_t  zero-extended, right-aligned read data; valid with o_ready

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0; all of arvalid, awvalid, wvalid, rready, o_ready, o_fault are 0; latched request cleared. An in-flight transaction is abandoned.
- Arbitration in IDLE: round-robin starting at the rr pointer. On grant, latch index, wen, size, addr and wdata into registers. All AXI outputs come from the latched copy, never from live inputs.
- rr pointer = (granted+1) mod NUM_REQUESTERS, updated on completion.
- Misalignment check at grant: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - State goes to FAULT. No AXI traffic is issued.
  - Next cycle: o_ready=1, o_fault=1, then back to IDLE.
- States and transitions:
  - IDLE -> R_AR (read grant), W_AW_W (write grant), or FAULT.
  - R_AR: arvalid=1.
    - On ar handshake -> R_DATA.
  - R_DATA: rready=1.
    - On r handshake: o_ready pulses, o_fault=(rresp!=OKAY), o_rdata holds the extracted lane.
    - Then -> IDLE.
  - W_AW_W: awvalid=1 and wvalid=1.
    - Both handshake -> W_B.
    - AW only -> W_W.
    - W only -> W_AW.
  - W_W / W_AW: the remaining valid=1; on handshake -> W_B.
  - W_B: bready=1.
    - On b handshake: o_ready pulses, o_fault=(bresp!=OKAY).
    - Then -> IDLE.
  - FAULT -> IDLE.
- bready=1 only in W_B. rready=1 only in R_DATA.
- A valid, once raised, stays high until its handshake. The latched request never changes mid-transaction.
- Latency: minimum read is 3 cycles from grant edge to o_ready (grant, AR, R). Minimum write is 3 cycles (grant, AW+W, B). The next grant is possible the cycle after o_ready.
- AXI addressing: araddr/awaddr = {addr[33:2],2'b00}; awsize=arsize=3'b010; len=0; burst FIXED.
- Write strobe:
  - byte: one-hot on addr[1:0].
  - halfword: addr[1] ? 1100 : 0011.
  - word: 1111.
- Write data replication: byte x4, halfword x2, word as-is.
- Read extraction: byte lane by addr[1:0], halfword by addr[1], zero-extended.
- o_ready, o_fault and o_rdata are registered-state Mealy outputs. They are driven only on the granted index; other indices read 0.
- i_valid dropping on a non-granted requester has no effect. Requesters must not drop i_valid before o_ready.
- Simultaneous valids on all requesters: each is served in turn with no starvation. For NUM_REQUESTERS=1, the pointer stays at 0.

Test Plan:
- Single requester 1 word read of 0x0_0000_1000. Slave returns 0xDEADBEEF, OKAY -> araddr=0x1000, arsize=2, o_ready[0] pulse with o_rdata[0]=0xDEADBEEF, o_fault[0]=0.
- Byte write 0xA5 at 0x1003 from requester 2 -> wstrb=1000, wdata=0xA5A5A5A5. o_ready[2] pulses only after the B handshake.
- All three requesters' valids held high continuously -> grant order 0,1,2,0,1,2 with exactly one o_ready per grant.
- AW accepted 4 cycles before W (slave delays wready) -> awvalid drops after its handshake, wvalid stays high, single completion.
- Halfword read at 0x1001 -> no arvalid ever asserted; o_ready=1, o_fault=1 on the cycle after grant. Word write that receives SLVERR -> o_fault=1.
- Reset asserted while in R_DATA -> all valids and readys go 0 immediately. After release, a new read to 0x2000 completes normally.
